// File: rtl/bsg_nonsynth_dramsim3_traffic_gen.sv
// Single-channel DRAM traffic generator: writes num_reqs_p self-describing words to
// consecutive addresses, then reads them back with bounded outstanding reads and checks each return.
module bsg_nonsynth_dramsim3_traffic_gen #(
    parameter int channel_addr_width_p = 32,
    parameter int data_width_p         = 64,
    parameter int num_reqs_p           = 16,
    parameter int base_addr_p          = 0,
    parameter int max_outstanding_p    = 4,
    parameter int seed_p               = 0,
    parameter int timeout_p            = 100000
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            start_i,
    output logic                            v_o,
    output logic                            write_not_read_o,
    output logic [channel_addr_width_p-1:0] ch_addr_o,
    input  logic                            yumi_i,
    output logic                            data_v_o,
    output logic [data_width_p-1:0]         data_o,
    input  logic                            data_yumi_i,
    input  logic                            data_v_i,
    input  logic [data_width_p-1:0]         data_i,
    input  logic                            write_done_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic [31:0]                     err_count_o
);
    localparam int idx_width_lp = $clog2(num_reqs_p + 1);
    localparam int half_lp      = data_width_p / 2;
    localparam int out_width_lp = $clog2(max_outstanding_p + 1);
    localparam int wd_width_lp  = $clog2(timeout_p + 1);

    localparam logic [idx_width_lp-1:0]         last_idx_lp = idx_width_lp'(num_reqs_p - 1);
    localparam logic [idx_width_lp-1:0]         num_idx_lp  = idx_width_lp'(num_reqs_p);
    localparam logic [half_lp-1:0]              num_half_lp = half_lp'(num_reqs_p);
    localparam logic [half_lp-1:0]              seed_lo_lp  = half_lp'(seed_p);
    localparam logic [out_width_lp-1:0]         max_out_lp  = out_width_lp'(max_outstanding_p);
    localparam logic [wd_width_lp-1:0]          wd_limit_lp = wd_width_lp'(timeout_p - 1);
    localparam logic [channel_addr_width_p-1:0] base_lp     = channel_addr_width_p'(base_addr_p);
    localparam logic [channel_addr_width_p-1:0] stride_lp   = channel_addr_width_p'(data_width_p / 8);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WRITE, ST_WDRAIN, ST_READ, ST_RWAIT, ST_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [idx_width_lp-1:0]   idx_q, idx_d;
    logic [idx_width_lp-1:0]   wdone_q, wdone_d;
    logic [idx_width_lp-1:0]   recv_q, recv_d;
    logic [out_width_lp-1:0]   out_q, out_d;
    logic [num_reqs_p-1:0]     bitmap_q, bitmap_d;
    logic [31:0]               err_cnt_q, err_cnt_d;
    logic                      error_q, error_d;
    logic [wd_width_lp-1:0]    wd_q, wd_d;

    logic                      req_v;
    logic                      rd_phase;
    logic [half_lp-1:0]        wr_lo, rd_lo, rd_hi, rd_k;
    logic                      rd_dup, rd_bad;
    logic [num_reqs_p-1:0]     rd_mask;

    // Word k carries k (keyed by the seed) in its low half and the complement in its high half.
    assign wr_lo = half_lp'(idx_q) ^ seed_lo_lp;
    assign rd_lo = data_i[half_lp-1:0];
    assign rd_hi = data_i[data_width_p-1:half_lp];
    assign rd_k  = rd_lo ^ seed_lo_lp;

    always_comb begin
        rd_dup  = 1'b0;
        rd_mask = '0;
        for (int i = 0; i < num_reqs_p; i++) begin
            if (rd_k == half_lp'(i)) begin
                rd_dup     = bitmap_q[i];
                rd_mask[i] = 1'b1;
            end
        end
    end

    assign rd_bad   = (rd_hi != ~rd_lo) || (rd_k >= num_half_lp) || rd_dup;
    assign rd_phase = (state_q == ST_READ) || (state_q == ST_RWAIT);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wdone_d   = wdone_q;
        recv_d    = recv_q;
        out_d     = out_q;
        bitmap_d  = bitmap_q;
        err_cnt_d = err_cnt_q;
        error_d   = error_q;
        wd_d      = '0;
        req_v     = 1'b0;

        if (write_done_i && (state_q == ST_WRITE || state_q == ST_WDRAIN) && wdone_q != num_idx_lp)
            wdone_d = wdone_q + 1'b1;

        // A return with nothing outstanding, or outside the read phases, is flagged but not counted.
        if (data_v_i) begin
            if (rd_phase && out_q != '0) begin
                recv_d = recv_q + 1'b1;
                out_d  = out_q - 1'b1;
                if (rd_bad) begin
                    error_d = 1'b1;
                    if (err_cnt_q != '1)
                        err_cnt_d = err_cnt_q + 1'b1;
                end else begin
                    bitmap_d = bitmap_q | rd_mask;
                end
            end else begin
                error_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d   = ST_WRITE;
                    idx_d     = '0;
                    wdone_d   = '0;
                    recv_d    = '0;
                    out_d     = '0;
                    bitmap_d  = '0;
                    err_cnt_d = '0;
                    error_d   = 1'b0;
                end
            end
            ST_WRITE: begin
                req_v = 1'b1;
                if (yumi_i) begin
                    if (!data_yumi_i) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (idx_q == last_idx_lp)
                            state_d = ST_WDRAIN;
                    end
                end
            end
            ST_WDRAIN: begin
                if (wdone_d == num_idx_lp) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                end
            end
            ST_READ: begin
                req_v = (out_q < max_out_lp);
                if (req_v && yumi_i) begin
                    idx_d = idx_q + 1'b1;
                    out_d = out_d + 1'b1;
                    if (idx_q == last_idx_lp)
                        state_d = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (recv_d == num_idx_lp)
                    state_d = ST_DONE;
            end
            default: ;
        endcase

        // Watchdog: timeout_p consecutive cycles without any handshake or return ends the run.
        if (state_q == ST_WDRAIN || rd_phase) begin
            if (yumi_i || write_done_i || data_v_i) begin
                wd_d = '0;
            end else if (wd_q == wd_limit_lp) begin
                error_d = 1'b1;
                state_d = ST_DONE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wdone_q   <= '0;
            recv_q    <= '0;
            out_q     <= '0;
            bitmap_q  <= '0;
            err_cnt_q <= '0;
            error_q   <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wdone_q   <= wdone_d;
            recv_q    <= recv_d;
            out_q     <= out_d;
            bitmap_q  <= bitmap_d;
            err_cnt_q <= err_cnt_d;
            error_q   <= error_d;
            wd_q      <= wd_d;
        end
    end

    assign v_o              = req_v;
    assign write_not_read_o = (state_q == ST_WRITE);
    assign data_v_o         = (state_q == ST_WRITE);
    assign ch_addr_o        = (state_q == ST_WRITE || state_q == ST_READ)
                              ? base_lp + channel_addr_width_p'(idx_q) * stride_lp : '0;
    assign data_o           = (state_q == ST_WRITE) ? {~wr_lo, wr_lo} : '0;
    assign busy_o           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o           = (state_q == ST_DONE);
    assign error_o          = error_q;
    assign err_count_o      = err_cnt_q;

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_traffic_gen.sv
// Bench for the DRAM traffic generator: a behavioural memory with selectable return
// policies answers requests while a scoreboard checks every request and the run outcome.
module tb_bsg_nonsynth_dramsim3_traffic_gen;
    localparam int N    = 4;
    localparam int W    = 64;
    localparam int AW   = 16;
    localparam int BASE = 'h100;
    localparam int MAXO = 2;
    localparam int SEED = 'h5A3C;
    localparam int TMO  = 50;

    localparam int M_INORDER = 0;
    localparam int M_LIFO    = 1;
    localparam int M_CORRUPT = 2;
    localparam int M_DELAY   = 3;
    localparam int M_DUP     = 4;
    localparam int M_RANDOM  = 5;

    logic          clk = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic          yumi_i = 1'b0;
    logic          data_yumi_i = 1'b0;
    logic          data_v_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          write_done_i = 1'b0;
    logic          v_o, write_not_read_o, data_v_o, busy_o, done_o, error_o;
    logic [AW-1:0] ch_addr_o;
    logic [W-1:0]  data_o;
    logic [31:0]   err_count_o;

    bsg_nonsynth_dramsim3_traffic_gen #(
        .channel_addr_width_p(AW), .data_width_p(W), .num_reqs_p(N), .base_addr_p(BASE),
        .max_outstanding_p(MAXO), .seed_p(SEED), .timeout_p(TMO)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i),
        .v_o(v_o), .write_not_read_o(write_not_read_o), .ch_addr_o(ch_addr_o),
        .yumi_i(yumi_i), .data_v_o(data_v_o), .data_o(data_o), .data_yumi_i(data_yumi_i),
        .data_v_i(data_v_i), .data_i(data_i), .write_done_i(write_done_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_count_o(err_count_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0]  exp_q[$];
    logic [AW:0]   exp_req_q[$];

    typedef struct { int k; int addr; int due; } pend_t;
    pend_t rd_pend[$];
    int    wd_pend[$];
    logic [W-1:0] mem [int];
    int    mode = M_INORDER;
    bit    yumi_rand = 1'b0;
    int    model_out = 0;
    int    rd_issued = 0;
    int    hold_seen = 0;
    int    cyc = 0;

    typedef struct { int mode; bit yumi_rand; bit mid_start; bit exp_error; int exp_cnt; } case_t;
    case_t cases[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] word_addr(input int k);
        return AW'(BASE + k * (W / 8));
    endfunction

    function automatic logic [W-1:0] word_data(input int k);
        logic [31:0] lo;
        lo = 32'(k ^ SEED);
        return {~lo, lo};
    endfunction

    // ---------------- memory model / request monitor ----------------
    initial begin
        bit           accept, stall_prev, new_rd;
        logic [AW-1:0] prev_addr;
        logic [W-1:0]  prev_data, rd_data;
        logic [AW:0]   req;
        int            sel, i, new_k;
        pend_t         p;
        stall_prev = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            yumi_i = 1'b0; data_yumi_i = 1'b0; write_done_i = 1'b0; data_v_i = 1'b0; data_i = '0;
            new_rd = 1'b0;
            new_k  = 0;
            if (!reset_n_i) begin
                rd_pend.delete(); wd_pend.delete();
                model_out = 0; rd_issued = 0; stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_v_held", v_o, 1);
                    check("stall_addr_held", ch_addr_o, prev_addr);
                    check("stall_data_held", data_o, prev_data);
                end
                if (busy_o && !v_o && model_out == MAXO) hold_seen++;
                accept = 1'b0;
                if (v_o) begin
                    accept = yumi_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                    if (accept) begin
                        yumi_i      = 1'b1;
                        data_yumi_i = write_not_read_o;
                        if (exp_req_q.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL unexpected_req: got addr 0x%0h wr %0b, required none", ch_addr_o, write_not_read_o);
                        end else begin
                            req = exp_req_q.pop_front();
                            check("req_kind_addr", {write_not_read_o, ch_addr_o}, req);
                            if (write_not_read_o) begin
                                check("wr_data", data_o, exp_q.pop_front());
                                check("wr_data_v", data_v_o, 1);
                                mem[int'(ch_addr_o)] = data_o;
                                wd_pend.push_back(cyc + (yumi_rand ? int'($urandom_range(1, 5)) : 2));
                            end else begin
                                check("rd_within_window", model_out < MAXO, 1);
                                new_rd = 1'b1;
                                new_k  = (int'(ch_addr_o) - BASE) / (W / 8);
                                rd_issued++;
                                model_out++;
                            end
                        end
                    end
                    stall_prev = !accept;
                    prev_addr  = ch_addr_o;
                    prev_data  = data_o;
                end else begin
                    stall_prev = 1'b0;
                end

                if (wd_pend.size() > 0 && wd_pend[0] <= cyc) begin
                    write_done_i = 1'b1;
                    void'(wd_pend.pop_front());
                end

                if (rd_pend.size() > 0) begin
                    sel = -1;
                    case (mode)
                        M_LIFO:   if (rd_pend.size() >= MAXO || rd_issued == N) sel = rd_pend.size() - 1;
                        M_RANDOM: begin
                            i = $urandom_range(0, rd_pend.size() - 1);
                            if (rd_pend[i].due <= cyc && $urandom_range(0, 1) == 1) sel = i;
                        end
                        default:  if (rd_pend[0].due <= cyc) sel = 0;
                    endcase
                    if (sel >= 0) begin
                        p = rd_pend[sel];
                        rd_pend.delete(sel);
                        if (!(mode == M_DUP && p.k == 3)) begin
                            rd_data = mem.exists(p.addr) ? mem[p.addr] : '0;
                            if (mode == M_CORRUPT && p.k == 2) rd_data[32] = ~rd_data[32];
                            if (mode == M_DUP && p.k == 2) rd_data = mem[int'(word_addr(1))];
                            data_v_i  = 1'b1;
                            data_i    = rd_data;
                            model_out--;
                        end
                    end
                end

                if (new_rd) begin
                    p.k    = new_k;
                    p.addr = int'(word_addr(new_k));
                    p.due  = cyc + ((mode == M_DELAY) ? 20 :
                                    (mode == M_RANDOM) ? int'($urandom_range(1, 6)) : 3);
                    rd_pend.push_back(p);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_run(input int m, input bit yr);
        exp_q.delete();
        exp_req_q.delete();
        for (int k = 0; k < N; k++) begin
            exp_q.push_back(word_data(k));
            exp_req_q.push_back({1'b1, word_addr(k)});
        end
        for (int k = 0; k < N; k++) exp_req_q.push_back({1'b0, word_addr(k)});
        rd_pend.delete(); wd_pend.delete();
        model_out = 0; rd_issued = 0; hold_seen = 0;
        mode = m; yumi_rand = yr;
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        check({tag, "_first_req_v"}, v_o, 1);
        check({tag, "_first_req_wr"}, write_not_read_o, 1);
        check({tag, "_first_req_addr"}, ch_addr_o, word_addr(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_v"}, v_o, 0);
        check({tag, "_wnr"}, write_not_read_o, 0);
        check({tag, "_addr"}, ch_addr_o, 0);
        check({tag, "_data_v"}, data_v_o, 0);
        check({tag, "_data"}, data_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_error"}, error_o, 0);
        check({tag, "_err_count"}, err_count_o, 0);
    endtask

    task automatic run_case(input case_t c, input string tag);
        int waited;
        load_run(c.mode, c.yumi_rand);
        pulse_start(tag);
        if (c.mid_start) begin
            @(negedge clk); start_i = 1'b1;
            @(negedge clk); start_i = 1'b0;
        end
        waited = 0;
        while (!done_o && waited < 800) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_done_reached"}, done_o, 1);
        check({tag, "_busy_clear"}, busy_o, 0);
        check({tag, "_error"}, error_o, c.exp_error);
        check({tag, "_err_count"}, err_count_o, c.exp_cnt);
        check({tag, "_reqs_left"}, exp_req_q.size(), 0);
        if (c.mode == M_DELAY) check({tag, "_reads_throttled"}, hold_seen > 0, 1);
        repeat (3) @(negedge clk);
        check({tag, "_done_held"}, done_o, 1);
        check({tag, "_idle_v"}, v_o, 0);
    endtask

    task automatic reset_mid_read();
        int waited;
        load_run(M_DELAY, 1'b0);
        pulse_start("rst");
        waited = 0;
        while (rd_issued < 1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("rst_reached_read", rd_issued >= 1, 1);
        #2 reset_n_i = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("rst_held");
        #2 reset_n_i = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        cases[0] = '{M_INORDER, 1'b0, 1'b0, 1'b0, 0};
        cases[1] = '{M_LIFO,    1'b0, 1'b0, 1'b0, 0};
        cases[2] = '{M_CORRUPT, 1'b0, 1'b0, 1'b1, 1};
        cases[3] = '{M_DELAY,   1'b0, 1'b0, 1'b0, 0};
        cases[4] = '{M_DUP,     1'b0, 1'b0, 1'b1, 1};
        cases[5] = '{M_RANDOM,  1'b1, 1'b0, 1'b0, 0};
        cases[6] = '{M_RANDOM,  1'b1, 1'b1, 1'b0, 0};
        cases[7] = '{M_LIFO,    1'b1, 1'b0, 1'b0, 0};

        reset_n_i = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        #2 reset_n_i = 1'b1;

        for (int i = 0; i < 8; i++) run_case(cases[i], $sformatf("case%0d", i));
        reset_mid_read();
        run_case(cases[0], "after_reset");
        run_case(cases[5], "after_reset_rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "global timeout");
    end

endmodule
